// File: rtl/periph_bridge_pkg.sv
// Shared address map, select decode and seven-segment constants for periph_bridge.
package periph_bridge_pkg;

  localparam logic [31:0] PERIPH_BASE = 32'hFFFF_F000;
  localparam logic [31:0] SEG_ADDR    = 32'hFFFF_F000;
  localparam logic [31:0] TIMER_ADDR  = 32'hFFFF_F020;
  localparam logic [31:0] LED_ADDR    = 32'hFFFF_F060;
  localparam logic [31:0] SW_ADDR     = 32'hFFFF_F070;
  localparam logic [31:0] BTN_ADDR    = 32'hFFFF_F078;

  localparam logic SEG_DP_OFF = 1'b1;

  typedef enum logic [2:0] {
    SEL_DRAM,
    SEL_SEG,
    SEL_TIMER,
    SEL_LED,
    SEL_SW,
    SEL_BTN,
    SEL_NONE
  } bus_sel_e;

  // Peripheral registers match on the full byte address; any other address
  // in the top 4 KiB is unmapped.
  function automatic bus_sel_e decode_sel(input logic [31:0] addr);
    bus_sel_e sel;
    if (addr < PERIPH_BASE) begin
      sel = SEL_DRAM;
    end else begin
      case (addr)
        SEG_ADDR:   sel = SEL_SEG;
        TIMER_ADDR: sel = SEL_TIMER;
        LED_ADDR:   sel = SEL_LED;
        SW_ADDR:    sel = SEL_SW;
        BTN_ADDR:   sel = SEL_BTN;
        default:    sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/periph_bridge_seg7_decode.sv
// Hex nibble to active-low seven-segment glyph, bit order {G,F,E,D,C,B,A}.
module seg7_decode (
  input  logic [3:0] hex,
  output logic [6:0] segs
);

  always_comb begin
    segs = 7'h7F;
    case (hex)
      4'h0: segs = 7'h40;
      4'h1: segs = 7'h79;
      4'h2: segs = 7'h24;
      4'h3: segs = 7'h30;
      4'h4: segs = 7'h19;
      4'h5: segs = 7'h12;
      4'h6: segs = 7'h02;
      4'h7: segs = 7'h78;
      4'h8: segs = 7'h00;
      4'h9: segs = 7'h10;
      4'hA: segs = 7'h08;
      4'hB: segs = 7'h03;
      4'hC: segs = 7'h46;
      4'hD: segs = 7'h21;
      4'hE: segs = 7'h06;
      4'hF: segs = 7'h0E;
      default: segs = 7'h7F;
    endcase
  end

endmodule

// File: rtl/periph_bridge.sv
// CPU bus bridge: DRAM pass-through plus SEG/LED/SW/BTN peripherals and a
// multiplexed 7-seg scanner. Define BRIDGE_TIMER_EN to add the free-running TIMER.
module periph_bridge
  import periph_bridge_pkg::*;
#(
  parameter int SCAN_DIV = 20000,
  parameter int SW_W     = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     Bus_addr,
  input  logic            Bus_wen,
  input  logic [31:0]     Bus_wdata,
  output logic [31:0]     Bus_rdata,
  output logic [13:0]     dram_addr,
  output logic            dram_wen,
  output logic [31:0]     dram_wdata,
  input  logic [31:0]     dram_rdata,
  input  logic [SW_W-1:0] sw,
  input  logic [4:0]      button,
  output logic [SW_W-1:0] led,
  output logic [7:0]      dig_en,
  output logic [7:0]      seg
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

  bus_sel_e        sel;
  logic [31:0]     seg_data;
  logic [SW_W-1:0] sw_meta;
  logic [SW_W-1:0] sw_sync;
  logic [4:0]      btn_meta;
  logic [4:0]      btn_sync;
  logic [PW-1:0]   pre;
  logic [2:0]      idx;
  logic [3:0]      nibble;
  logic [6:0]      glyph;

  always_comb begin
    sel = decode_sel(Bus_addr);
  end

  assign dram_addr  = Bus_addr[15:2];
  assign dram_wdata = Bus_wdata;
  assign dram_wen   = Bus_wen && (sel == SEL_DRAM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_data <= '0;
      led      <= '0;
    end else if (Bus_wen) begin
      if (sel == SEL_SEG) seg_data <= Bus_wdata;
      if (sel == SEL_LED) led      <= Bus_wdata[SW_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      sw_meta  <= sw;
      sw_sync  <= sw_meta;
      btn_meta <= button;
      btn_sync <= btn_meta;
    end
  end

`ifdef BRIDGE_TIMER_EN
  logic [31:0] timer;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (Bus_wen && (sel == SEL_TIMER)) begin
      timer <= Bus_wdata;
    end else begin
      timer <= timer + 32'd1;
    end
  end
`endif

  always_comb begin
    Bus_rdata = '0;
    case (sel)
      SEL_DRAM:  Bus_rdata = dram_rdata;
      SEL_SEG:   Bus_rdata = seg_data;
`ifdef BRIDGE_TIMER_EN
      SEL_TIMER: Bus_rdata = timer;
`endif
      SEL_LED:   Bus_rdata[SW_W-1:0] = led;
      SEL_SW:    Bus_rdata[SW_W-1:0] = sw_sync;
      SEL_BTN:   Bus_rdata[4:0] = btn_sync;
      default:   Bus_rdata = '0;
    endcase
  end

  // Scanner runs independently of bus traffic; only reset touches pre/idx.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == PRE_LAST) begin
      pre <= '0;
      idx <= idx + 3'd1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign nibble = seg_data[{idx, 2'b00} +: 4];

  seg7_decode u_seg7_decode (
    .hex  (nibble),
    .segs (glyph)
  );

  assign seg    = {SEG_DP_OFF, glyph};
  assign dig_en = rst_n ? ~(8'b1 << idx) : 8'hFF;

endmodule
